// File: rtl/siteswap_validator.sv
// siteswap_validator: collects up to seven siteswap digits serially, checks that
// the landing slots form a permutation, then divides the digit sum by the
// period to get the ball count. All outputs are registered.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  S_IDLE   | collecting digits into the entry buffer
//  S_CHECK  | one index per cycle, marking landing slots in the mask
//  S_DIVIDE | repeated subtraction of the period from the digit sum
//  S_DONE   | validated pattern presented, pattern_valid_out held high
//  S_ERROR  | entry rejected, error_out held high with a reason code
module siteswap_validator #(
    parameter int MAX_PERIOD = 7
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [2:0] digit_in,
    input  logic       digit_valid_in,
    input  logic       commit_in,
    input  logic       clear_in,
    output logic [2:0] pattern_out [MAX_PERIOD-1:0],
    output logic [2:0] period_out,
    output logic [2:0] num_balls_out,
    output logic       pattern_valid_out,
    output logic       error_out,
    output logic [1:0] error_code_out,
    output logic       busy_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DIVIDE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_COLLISION = 2'd1;
    localparam logic [1:0] ERR_EMPTY     = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd3;

    state_t     state;
    logic [2:0] digit_buf [MAX_PERIOD];
    logic [2:0] count;
    logic [5:0] sum;
    logic [6:0] mask;
    logic [2:0] idx;
    logic [2:0] n_len;
    logic [5:0] rem;
    logic [2:0] quo;
    logic [3:0] slot;

    // Landing slot of the throw at idx: (idx + digit) mod n, by bounded subtraction.
    always_comb begin
        slot = {1'b0, idx} + {1'b0, digit_buf[idx]};
        for (int k = 0; k < 13; k++) begin
            if (slot >= {1'b0, n_len}) begin
                slot = slot - {1'b0, n_len};
            end
        end
    end

    // Main controller: entry buffer, permutation check, division and output registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state             <= S_IDLE;
            count             <= 3'd0;
            sum               <= 6'd0;
            mask              <= 7'd0;
            idx               <= 3'd0;
            n_len             <= 3'd0;
            rem               <= 6'd0;
            quo               <= 3'd0;
            period_out        <= 3'd0;
            num_balls_out     <= 3'd0;
            pattern_valid_out <= 1'b0;
            error_out         <= 1'b0;
            error_code_out    <= ERR_NONE;
            busy_out          <= 1'b0;
            for (int k = 0; k < MAX_PERIOD; k++) begin
                digit_buf[k]   <= 3'd0;
                pattern_out[k] <= 3'd0;
            end
        end else if (clear_in) begin
            // Displayed pattern, period and ball count survive a clear.
            state             <= S_IDLE;
            count             <= 3'd0;
            sum               <= 6'd0;
            mask              <= 7'd0;
            idx               <= 3'd0;
            pattern_valid_out <= 1'b0;
            error_out         <= 1'b0;
            error_code_out    <= ERR_NONE;
            busy_out          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (digit_valid_in && (count == 3'd7)) begin
                        state          <= S_ERROR;
                        error_out      <= 1'b1;
                        error_code_out <= ERR_OVERFLOW;
                    end else if (digit_valid_in && commit_in) begin
                        // Digit lands first; the commit sees the grown entry.
                        digit_buf[count] <= digit_in;
                        count            <= 3'(count + 3'd1);
                        sum              <= sum + {3'b000, digit_in};
                        n_len            <= 3'(count + 3'd1);
                        mask             <= 7'd0;
                        idx              <= 3'd0;
                        busy_out         <= 1'b1;
                        state            <= S_CHECK;
                    end else if (digit_valid_in) begin
                        digit_buf[count] <= digit_in;
                        count            <= 3'(count + 3'd1);
                        sum              <= sum + {3'b000, digit_in};
                    end else if (commit_in) begin
                        if (count == 3'd0) begin
                            state          <= S_ERROR;
                            error_out      <= 1'b1;
                            error_code_out <= ERR_EMPTY;
                        end else begin
                            n_len    <= count;
                            mask     <= 7'd0;
                            idx      <= 3'd0;
                            busy_out <= 1'b1;
                            state    <= S_CHECK;
                        end
                    end
                end

                S_CHECK: begin
                    if (mask[slot[2:0]]) begin
                        state          <= S_ERROR;
                        error_out      <= 1'b1;
                        error_code_out <= ERR_COLLISION;
                        busy_out       <= 1'b0;
                    end else begin
                        mask[slot[2:0]] <= 1'b1;
                        if (idx == 3'(n_len - 3'd1)) begin
                            rem   <= sum;
                            quo   <= 3'd0;
                            state <= S_DIVIDE;
                        end else begin
                            idx <= 3'(idx + 3'd1);
                        end
                    end
                end

                S_DIVIDE: begin
                    if (rem >= {3'b000, n_len}) begin
                        rem <= rem - {3'b000, n_len};
                        quo <= 3'(quo + 3'd1);
                    end else begin
                        for (int k = 0; k < MAX_PERIOD; k++) begin
                            pattern_out[k] <= (3'(k) < n_len) ? digit_buf[k] : 3'd0;
                        end
                        period_out        <= n_len;
                        num_balls_out     <= quo;
                        pattern_valid_out <= 1'b1;
                        busy_out          <= 1'b0;
                        state             <= S_DONE;
                    end
                end

                S_DONE, S_ERROR: begin
                    // A fresh digit starts a new entry; stray commits are dropped.
                    if (digit_valid_in) begin
                        for (int k = 0; k < MAX_PERIOD; k++) begin
                            digit_buf[k] <= (k == 0) ? digit_in : 3'd0;
                        end
                        count             <= 3'd1;
                        sum               <= {3'b000, digit_in};
                        mask              <= 7'd0;
                        pattern_valid_out <= 1'b0;
                        error_out         <= 1'b0;
                        error_code_out    <= ERR_NONE;
                        state             <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_siteswap_validator.sv
// Bench for siteswap_validator: directed scenarios followed by randomized
// entries, all checked through a scoreboard against a siteswap reference model.
module tb_siteswap_validator;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic [2:0] digit_in = 3'd0;
    logic       digit_valid_in = 1'b0;
    logic       commit_in = 1'b0;
    logic       clear_in = 1'b0;
    logic [2:0] pattern_out [6:0];
    logic [2:0] period_out;
    logic [2:0] num_balls_out;
    logic       pattern_valid_out;
    logic       error_out;
    logic [1:0] error_code_out;
    logic       busy_out;

    siteswap_validator dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .digit_in(digit_in),
        .digit_valid_in(digit_valid_in),
        .commit_in(commit_in),
        .clear_in(clear_in),
        .pattern_out(pattern_out),
        .period_out(period_out),
        .num_balls_out(num_balls_out),
        .pattern_valid_out(pattern_valid_out),
        .error_out(error_out),
        .error_code_out(error_code_out),
        .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int pat_now();
        int r = 0;
        for (int k = 0; k < 7; k++) r |= int'(pattern_out[k]) << (3 * k);
        return r;
    endfunction

    typedef struct packed {
        int         rise_cyc;
        int         busy_cyc;
        logic [20:0] pat;
        logic [2:0] period;
        logic [2:0] balls;
        logic [1:0] code;
        logic       is_err;
    } exp_t;

    exp_t sb[$];

    // ---------------- reference model ----------------
    int          digs[$];
    bit          collecting = 1'b1;
    bit          suppress = 1'b0;
    logic [20:0] last_pat = '0;
    logic [2:0]  last_period = '0;
    logic [2:0]  last_balls = '0;

    task automatic model_reset();
        digs.delete();
        collecting  = 1'b1;
        last_pat    = '0;
        last_period = '0;
        last_balls  = '0;
    endtask

    task automatic push_exp(input exp_t e);
        if (!suppress) begin
            sb.push_back(e);
            if (!e.is_err) begin
                last_pat    = e.pat;
                last_period = e.period;
                last_balls  = e.balls;
            end
        end
    endtask

    function automatic exp_t err_item(input int code, input int rise, input int busy);
        exp_t e;
        e.is_err   = 1'b1;
        e.code     = 2'(code);
        e.rise_cyc = rise;
        e.busy_cyc = busy;
        e.pat      = last_pat;
        e.period   = last_period;
        e.balls    = last_balls;
        return e;
    endfunction

    // Siteswap rule: throws (i + d[i]) mod n must hit every slot exactly once.
    function automatic exp_t evaluate(input int c);
        exp_t e;
        int   n = digs.size();
        int   total = 0;
        bit   seen[7];
        int   coll = -1;
        for (int i = 0; i < 7; i++) seen[i] = 1'b0;
        for (int i = 0; i < n; i++) begin
            int s = (i + digs[i]) % n;
            total += digs[i];
            if (coll < 0) begin
                if (seen[s]) coll = i;
                else seen[s] = 1'b1;
            end
        end
        if (coll >= 0) return err_item(1, c + coll + 2, coll + 1);
        e.is_err   = 1'b0;
        e.code     = 2'd0;
        e.period   = 3'(n);
        e.balls    = 3'(total / n);
        e.pat      = '0;
        for (int k = 0; k < n; k++) e.pat[k*3 +: 3] = 3'(digs[k]);
        e.rise_cyc = c + n + total / n + 2;
        e.busy_cyc = n + total / n + 1;
        return e;
    endfunction

    task automatic model_step(input bit dv, input int d, input bit cm, input bit cl, input int c);
        if (cl) begin
            digs.delete();
            collecting = 1'b1;
        end else if (!collecting) begin
            if (dv) begin
                digs.delete();
                digs.push_back(d);
                collecting = 1'b1;
            end
        end else begin
            if (dv && digs.size() == 7) begin
                push_exp(err_item(3, c + 1, 0));
                collecting = 1'b0;
            end else begin
                if (dv) digs.push_back(d);
                if (cm) begin
                    if (digs.size() == 0) push_exp(err_item(2, c + 1, 0));
                    else push_exp(evaluate(c));
                    collecting = 1'b0;
                end
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit dv, input int d, input bit cm, input bit cl);
        int c = cyc;
        digit_valid_in = dv;
        digit_in       = 3'(d);
        commit_in      = cm;
        clear_in       = cl;
        model_step(dv, d, cm, cl, c);
        @(posedge clk_in);
        #1;
        digit_valid_in = 1'b0;
        commit_in      = 1'b0;
        clear_in       = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
    endtask

    task automatic enter(input int dq[$]);
        foreach (dq[i]) drive(1, dq[i], 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pattern"}, pat_now(), 0);
        check({tag, "_period"}, period_out, 0);
        check({tag, "_balls"}, num_balls_out, 0);
        check({tag, "_valid"}, pattern_valid_out, 0);
        check({tag, "_error"}, error_out, 0);
        check({tag, "_code"}, error_code_out, 0);
        check({tag, "_busy"}, busy_out, 0);
    endtask

    // ---------------- monitor ----------------
    bit   prev_v = 1'b0, prev_e = 1'b0, busy_prev = 1'b0, busy_end_now = 1'b0;
    int   run = 0, last_run = 0;
    exp_t got;

    // Pops one expectation per rising edge of pattern_valid_out or error_out.
    always @(negedge clk_in) begin
        if (rst_in) begin
            prev_v    = 1'b0;
            prev_e    = 1'b0;
            busy_prev = 1'b0;
            run       = 0;
        end else begin
            busy_end_now = 1'b0;
            if (busy_out) run++;
            else if (busy_prev) begin
                last_run     = run;
                run          = 0;
                busy_end_now = 1'b1;
            end
            busy_prev = busy_out;
            if ((pattern_valid_out && !prev_v) || (error_out && !prev_e)) begin
                check("result_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    check("kind", int'({pattern_valid_out, error_out}), got.is_err ? 1 : 2);
                    check("error_code", error_code_out, got.code);
                    check("period", period_out, got.period);
                    check("num_balls", num_balls_out, got.balls);
                    check("pattern", pat_now(), int'(got.pat));
                    check("rise_cycle", cyc, got.rise_cyc);
                    check("busy_cycles", busy_end_now ? last_run : 0, got.busy_cyc);
                end
            end
            prev_v = pattern_valid_out;
            prev_e = error_out;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int dq[$];
        repeat (3) @(posedge clk_in);
        #1;
        check_all_zero("reset");
        rst_in = 1'b0;
        model_reset();

        dq = '{3};          enter(dq); drive(0, 0, 1, 0); idle(10);
        dq = '{5, 3, 1};    enter(dq); drive(0, 0, 1, 0); idle(12);
        dq = '{5, 4, 3};    enter(dq); drive(0, 0, 1, 0); idle(6);
        drive(0, 0, 0, 1);  drive(0, 0, 1, 0); idle(3);
        for (int i = 0; i < 8; i++) drive(1, 1, 0, 0);
        idle(2);
        drive(1, 4, 0, 0);
        check("new_entry_valid", pattern_valid_out, 0);
        check("new_entry_error", error_out, 0);
        check("new_entry_code", error_code_out, 0);
        drive(0, 0, 1, 0); idle(10);
        dq = '{4, 4};       enter(dq); drive(1, 1, 1, 0); idle(12);

        dq = '{7, 5, 3, 0, 0}; enter(dq);
        suppress = 1'b1; drive(0, 0, 1, 0); idle(1); drive(0, 0, 0, 1); suppress = 1'b0;
        check("clear_busy", busy_out, 0);
        check("clear_valid", pattern_valid_out, 0);
        check("clear_error", error_out, 0);
        idle(20);

        dq = '{7, 5, 3, 0, 0}; enter(dq);
        suppress = 1'b1; drive(0, 0, 1, 0); idle(1);
        rst_in = 1'b1; drive(0, 0, 0, 0);
        check_all_zero("midrst");
        rst_in = 1'b0; suppress = 1'b0;
        model_reset();
        idle(2);

        for (int it = 0; it < 250; it++) begin
            int  r = $urandom_range(0, 99);
            bit  merge = ($urandom_range(0, 3) == 0);
            bit  abort = (r >= 88);
            dq.delete();
            if ($urandom_range(0, 9) == 0) drive(0, 0, 0, 1);
            if (r < 45 || abort) begin
                int n = $urandom_range(1, 7);
                int p[7];
                for (int i = 0; i < 7; i++) p[i] = i;
                for (int i = n - 1; i > 0; i--) begin
                    int j = $urandom_range(0, i);
                    int t = p[i];
                    p[i] = p[j];
                    p[j] = t;
                end
                for (int i = 0; i < n; i++) begin
                    int base = (p[i] - i + n) % n;
                    dq.push_back(base + n * $urandom_range(0, (7 - base) / n));
                end
            end else if (r < 75) begin
                int n = $urandom_range(1, 7);
                for (int i = 0; i < n; i++) dq.push_back($urandom_range(0, 7));
            end else if (r < 82) begin
                drive(0, 0, 0, 1);
                merge = 1'b0;
            end else begin
                for (int i = 0; i < 8; i++) dq.push_back($urandom_range(0, 7));
                merge = 1'b0;
            end
            if (r >= 75 && r < 82) begin
                drive(0, 0, 1, 0);
            end else begin
                suppress = 1'b0;
                foreach (dq[i]) begin
                    idle($urandom_range(0, 2));
                    if (i == dq.size() - 1 && merge) begin
                        suppress = abort;
                        drive(1, dq[i], 1, 0);
                    end else begin
                        drive(1, dq[i], 0, 0);
                    end
                end
                if (dq.size() < 8 && !merge) begin
                    suppress = abort;
                    drive(0, 0, 1, 0);
                end
                if (abort) begin
                    idle($urandom_range(0, 1));
                    drive(0, 0, 0, 1);
                    suppress = 1'b0;
                end
            end
            idle(18);
            if ($urandom_range(0, 4) == 0) begin
                drive(0, 0, 1, 0);
                idle(2);
            end
        end

        idle(20);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
